// File: rtl/net_ovr_pkg.sv
// net_ovr_pkg: shared types, parameter checks and round-robin pick helper for the override arbiter
package net_ovr_pkg;
  typedef enum logic [1:0] {IDLE, OWN, GAP} state_t;
  localparam int MAX_REQ = 32;
  localparam int IDX_W = 5;
  typedef struct packed {
    logic valid;
    logic [IDX_W-1:0] idx;
  } pick_t;
  function automatic bit params_ok(input int num_req, input int max_hold, input int data_w);
    return num_req >= 2 && num_req <= MAX_REQ && max_hold >= 1 && data_w >= 1;
  endfunction
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] req, input logic [IDX_W-1:0] ptr, input int n);
    pick_t p;
    int j;
    logic [IDX_W-1:0] jj;
    p = '0;
    for (int k = MAX_REQ - 1; k >= 0; k--) begin
      if (k < n) begin
        j = int'(ptr) + k;
        if (j >= n) j = j - n;
        jj = j[IDX_W-1:0];
        if (req[jj]) begin
          p.valid = 1'b1;
          p.idx = jj;
        end
      end
    end
    return p;
  endfunction
endpackage

// File: rtl/ovr_rr_pick.sv
// ovr_rr_pick: combinational round-robin picker, first asserted req at ptr, ptr+1, ... wrapping
module ovr_rr_pick
  import net_ovr_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] idx,
  output logic          valid
);
  pick_t p;
  // search from ptr upward, modulo N
  always_comb begin
    p = rr_pick(MAX_REQ'(req), IDX_W'(ptr), N);
    idx = IW'(p.idx);
    valid = p.valid;
  end
endmodule

// File: rtl/net_override_arbiter.sv
// net_override_arbiter: round-robin override of a shared net with fairness timeout
module net_override_arbiter
  import net_ovr_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W = 8,
  parameter int MAX_HOLD = 4,
  localparam int IW = $clog2(NUM_REQ),
  localparam int CW = MAX_HOLD > 1 ? $clog2(MAX_HOLD) : 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [DATA_W-1:0]               func_val,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]  req_val,
  output logic [NUM_REQ-1:0]              grant,
  output logic [IW-1:0]                   owner_id,
  output logic                            override_active,
  output logic                            preempt,
  output logic [DATA_W-1:0]               out_val
);
  if (!params_ok(NUM_REQ, MAX_HOLD, DATA_W)) begin : g_bad_params
    $error("net_override_arbiter: invalid parameters");
  end
  state_t state, state_n;
  logic [IW-1:0] ptr, ptr_n, owner_n, idx, ptr_wrap;
  logic [CW-1:0] cnt, cnt_n;
  logic [NUM_REQ-1:0] grant_n;
  logic preempt_n, valid, own_req, others, at_max;
  ovr_rr_pick #(.N(NUM_REQ)) u_pick (
    .req(req),
    .ptr(ptr),
    .idx(idx),
    .valid(valid)
  );
  assign override_active = |grant;
  assign out_val = override_active ? req_val[owner_id] : func_val;
  assign own_req = |(req & grant);
  assign others = |(req & ~grant);
  assign at_max = cnt == CW'(MAX_HOLD - 1);
  assign ptr_wrap = owner_id == IW'(NUM_REQ - 1) ? '0 : owner_id + IW'(1);
  // next state: arbitrate in IDLE/GAP, count and release/preempt in OWN
  always_comb begin
    state_n = state;
    ptr_n = ptr;
    cnt_n = cnt;
    owner_n = owner_id;
    preempt_n = 1'b0;
    if (state == OWN) begin
      cnt_n = at_max ? cnt : cnt + CW'(1);
      if (!own_req || (at_max && others)) begin
        state_n = GAP;
        owner_n = '0;
        cnt_n = '0;
        preempt_n = own_req;
        ptr_n = ptr_wrap;
      end
    end else begin
      state_n = valid ? OWN : IDLE;
      owner_n = valid ? idx : '0;
      cnt_n = '0;
    end
    grant_n = state_n == OWN ? NUM_REQ'(1) << owner_n : '0;
  end
  // state, pointer, hold counter and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr <= '0;
      cnt <= '0;
      owner_id <= '0;
      grant <= '0;
      preempt <= 1'b0;
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      cnt <= cnt_n;
      owner_id <= owner_n;
      grant <= grant_n;
      preempt <= preempt_n;
    end
  end
endmodule

// File: tb/tb_net_override_arbiter.sv
// tb_net_override_arbiter: scoreboard bench with directed vectors for net_override_arbiter
module tb_net_override_arbiter;
  logic clk, rst_n;
  logic [7:0] func_val;
  logic [3:0] req;
  logic [3:0][7:0] req_val, rv;
  logic [3:0] grant;
  logic [1:0] owner_id;
  logic override_active, preempt;
  logic [7:0] out_val;
  int cyc = 0;
  int tests = 0;
  int fails = 0;
  typedef struct {
    int cyc;
    logic [3:0] g;
    logic [1:0] o;
    logic p;
    logic [7:0] v;
    string nm;
  } exp_t;
  exp_t q[$];
  net_override_arbiter #(.NUM_REQ(4), .DATA_W(8), .MAX_HOLD(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .func_val(func_val),
    .req(req),
    .req_val(req_val),
    .grant(grant),
    .owner_id(owner_id),
    .override_active(override_active),
    .preempt(preempt),
    .out_val(out_val)
  );
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc <= cyc + 1;
  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic ex(input logic [3:0] g, input logic [1:0] o, input logic p, input logic [7:0] v, input string nm);
    q.push_back('{cyc, g, o, p, v, nm});
  endtask
  task automatic do_reset();
    req = '0;
    rst_n = 0;
    step();
    rst_n = 1;
  endtask
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        tests++;
        if (grant !== e.g || owner_id !== e.o || override_active !== (|e.g) || preempt !== e.p || out_val !== e.v) begin
          fails++;
          $display("FAIL %s cyc=%0d got g=%b o=%0d a=%b p=%b v=%h exp g=%b o=%0d a=%b p=%b v=%h",
                   e.nm, cyc, grant, owner_id, override_active, preempt, out_val,
                   e.g, e.o, |e.g, e.p, e.v);
        end
      end
    end
  end
  initial begin
    rv = {8'hD4, 8'hC3, 8'hB1, 8'hA0};
    req_val = rv;
    func_val = 8'h5A;
    req = '0;
    rst_n = 0;
    step(2);
    ex(4'b0000, 0, 0, 8'h5A, "reset");
    rst_n = 1;
    step();
    func_val = 8'h11;
    ex(4'b0000, 0, 0, 8'h11, "func_follow");
    step();
    req = 4'b0100;
    for (int k = 1; k <= 5; k++) begin
      step();
      if (k == 3) begin
        rv[2] = 8'h3C;
        req_val = rv;
      end
      ex(4'b0100, 2, 0, rv[2], "t2_sole_own");
      if (k == 5) req = '0;
    end
    step();
    ex(4'b0000, 0, 0, 8'h11, "t2_release_gap");
    step();
    ex(4'b0000, 0, 0, 8'h11, "t2_idle");
    rv[2] = 8'hC3;
    req_val = rv;
    do_reset();
    req = 4'b1001;
    for (int k = 1; k <= 4; k++) begin
      step();
      ex(4'b0001, 0, 0, 8'hA0, "t3_own0");
    end
    step();
    ex(4'b0000, 0, 1, 8'h11, "t3_gap_preempt");
    tests++;
    if (preempt !== 1'b1 || grant !== 4'b0000) begin
      fails++;
      $display("FAIL t3_direct_preempt p=%b g=%b", preempt, grant);
    end
    step();
    ex(4'b1000, 3, 0, 8'hD4, "t3_own3");
    req = '0;
    step(3);
    do_reset();
    req = 4'b1111;
    for (int r = 0; r <= 4; r++) begin
      for (int k = 0; k < 4; k++) begin
        step();
        ex(4'b0001 << (r % 4), 2'(r % 4), 0, rv[r % 4], "t4_rotate_own");
      end
      if (r < 4) begin
        step();
        ex(4'b0000, 0, 1, 8'h11, "t4_rotate_gap");
      end
    end
    req = '0;
    step(3);
    do_reset();
    req = 4'b0011;
    for (int k = 1; k <= 4; k++) begin
      step();
      ex(4'b0001, 0, 0, 8'hA0, "t5_own0");
      if (k == 4) req = 4'b0010;
    end
    step();
    ex(4'b0000, 0, 0, 8'h11, "t5_release_wins");
    step();
    ex(4'b0010, 1, 0, 8'hB1, "t5_own1");
    req = '0;
    step(3);
    do_reset();
    req = 4'b0100;
    step();
    ex(4'b0100, 2, 0, 8'hC3, "t6_own2");
    step();
    #1;
    rst_n = 0;
    ex(4'b0000, 0, 0, 8'h11, "t6_async_reset");
    #1;
    tests++;
    if (grant !== 4'b0000 || override_active !== 1'b0 || out_val !== func_val) begin
      fails++;
      $display("FAIL t6_direct_async g=%b a=%b v=%h", grant, override_active, out_val);
    end
    step();
    ex(4'b0000, 0, 0, 8'h11, "t6_in_reset");
    req = 4'b0110;
    rst_n = 1;
    step();
    ex(4'b0010, 1, 0, 8'hB1, "t6_ptr0_after_reset");
    req = '0;
    for (int i = 0; i < 5 && q.size() > 0; i++) step();
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      tests++;
      fails++;
      $display("FAIL %s never checked, due cyc=%0d now cyc=%0d", e.nm, e.cyc, cyc);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
